// File: rtl/uart_yukleyici.sv
// UART boot loader: programs the UART baud divisor, reads a 4-byte little-endian
// length header, then streams the payload bytes into memory as packed 32-bit words.
`ifndef ADRES_BIT
`define ADRES_BIT 32
`endif
`ifndef VERI_BIT
`define VERI_BIT 32
`endif
`ifndef UART_BASE_ADDR
`define UART_BASE_ADDR 32'h1000_0000
`endif
`ifndef UART_CTRL_REG
`define UART_CTRL_REG 32'h0000_000C
`endif
`ifndef UART_RDATA_REG
`define UART_RDATA_REG 32'h0000_0004
`endif

module uart_yukleyici #(
  parameter logic [31:0] BASLANGIC_ADRES = 32'h4000_0000,
  parameter logic [31:0] MAKS_BAYT       = 32'd65536,
  parameter logic [15:0] BAUD_BOLEN      = 16'd868
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  basla_i,
  output logic [`ADRES_BIT-1:0] cek_adres_o,
  output logic [`VERI_BIT-1:0]  cek_veri_o,
  output logic                  cek_yaz_o,
  output logic                  cek_gecerli_o,
  input  logic                  cek_hazir_i,
  input  logic [`VERI_BIT-1:0]  uart_veri_i,
  input  logic                  uart_gecerli_i,
  output logic                  uart_hazir_o,
  output logic [`ADRES_BIT-1:0] bellek_adres_o,
  output logic [`VERI_BIT-1:0]  bellek_veri_o,
  output logic                  bellek_gecerli_o,
  input  logic                  bellek_hazir_i,
  output logic                  mesgul_o,
  output logic                  bitti_o,
  output logic                  hata_o
);

  typedef enum logic [3:0] {
    BOSTA, AYAR_YAZ, BOY_ISTE, BOY_BEKLE, VERI_ISTE,
    VERI_BEKLE, BELLEK_YAZ, BITTI, HATA
  } durum_t;

  durum_t                 durum, sonraki;
  logic [31:0]            uzunluk;
  logic [31:0]            bayt_say;
  logic [31:0]            kelime;
  logic [1:0]             boy_say;
  logic [`ADRES_BIT-1:0]  kelime_idx;

  logic                   uart_al;
  logic                   cek_el;
  logic                   bellek_el;
  logic [7:0]             gelen;
  logic [31:0]            tam_boy;
  logic                   veri_unused;

  assign gelen       = uart_veri_i[7:0];
  assign veri_unused = ^uart_veri_i[`VERI_BIT-1:8];
  // Header byte 4 lands in [31:24]; evaluate the complete length in the same cycle.
  assign tam_boy     = {gelen, uzunluk[23:0]};

  always_ff @(posedge clk_i) begin
    if (!rstn_i) durum <= BOSTA;
    else         durum <= sonraki;
  end

  always_comb begin
    sonraki          = durum;
    cek_adres_o      = '0;
    cek_veri_o       = '0;
    cek_yaz_o        = 1'b0;
    cek_gecerli_o    = 1'b0;
    uart_hazir_o     = 1'b0;
    bellek_adres_o   = '0;
    bellek_veri_o    = '0;
    bellek_gecerli_o = 1'b0;
    bitti_o          = 1'b0;
    hata_o           = 1'b0;
    mesgul_o         = 1'b1;
    case (durum)
      AYAR_YAZ: begin
        cek_gecerli_o = 1'b1;
        cek_yaz_o     = 1'b1;
        cek_adres_o   = `ADRES_BIT'(`UART_BASE_ADDR | `UART_CTRL_REG);
        cek_veri_o    = `VERI_BIT'({BAUD_BOLEN, 14'd0, 2'b11});
      end
      BOY_ISTE, VERI_ISTE: begin
        cek_gecerli_o = 1'b1;
        cek_adres_o   = `ADRES_BIT'(`UART_BASE_ADDR | `UART_RDATA_REG);
      end
      BOY_BEKLE, VERI_BEKLE: uart_hazir_o = 1'b1;
      BELLEK_YAZ: begin
        bellek_gecerli_o = 1'b1;
        bellek_adres_o   = `ADRES_BIT'(BASLANGIC_ADRES) + (kelime_idx << 2);
        bellek_veri_o    = `VERI_BIT'(kelime);
      end
      BITTI: begin
        bitti_o  = 1'b1;
        mesgul_o = 1'b0;
      end
      HATA: begin
        hata_o   = 1'b1;
        mesgul_o = 1'b0;
      end
      default: mesgul_o = 1'b0;
    endcase

    cek_el    = cek_gecerli_o & cek_hazir_i;
    uart_al   = uart_hazir_o & uart_gecerli_i;
    bellek_el = bellek_gecerli_o & bellek_hazir_i;

    case (durum)
      BOSTA:      if (basla_i) sonraki = AYAR_YAZ;
      AYAR_YAZ:   if (cek_el) sonraki = BOY_ISTE;
      BOY_ISTE:   if (cek_el) sonraki = BOY_BEKLE;
      VERI_ISTE:  if (cek_el) sonraki = VERI_BEKLE;
      BOY_BEKLE: begin
        if (uart_al) begin
          if (boy_say != 2'd3)          sonraki = BOY_ISTE;
          else if (tam_boy == 32'd0)    sonraki = BITTI;
          else if (tam_boy > MAKS_BAYT) sonraki = HATA;
          else                          sonraki = VERI_ISTE;
        end
      end
      VERI_BEKLE: begin
        if (uart_al) begin
          if (bayt_say[1:0] == 2'd3 || bayt_say + 32'd1 == uzunluk) sonraki = BELLEK_YAZ;
          else                                                      sonraki = VERI_ISTE;
        end
      end
      BELLEK_YAZ: begin
        if (bellek_el) sonraki = (bayt_say != uzunluk) ? VERI_ISTE : BITTI;
      end
      default: sonraki = durum;
    endcase
  end

  // Byte/word assembly; the word register is cleared after every memory write so a
  // short final word carries zeros in its unfilled upper bytes.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      uzunluk    <= '0;
      bayt_say   <= '0;
      kelime     <= '0;
      boy_say    <= '0;
      kelime_idx <= '0;
    end else begin
      if (uart_al && durum == BOY_BEKLE) begin
        uzunluk[{boy_say, 3'b000} +: 8] <= gelen;
        boy_say <= boy_say + 2'd1;
      end
      if (uart_al && durum == VERI_BEKLE) begin
        kelime[{bayt_say[1:0], 3'b000} +: 8] <= gelen;
        bayt_say <= bayt_say + 32'd1;
      end
      if (bellek_el) begin
        kelime_idx <= kelime_idx + 1'b1;
        kelime     <= '0;
      end
    end
  end

endmodule
